// File: rtl/neuron_mac_seq_pkg.sv
// Shared definitions for the time-multiplexed neuron.
// Holds the controller state encoding plus the small elaboration-time
// helpers (ceil-log2 and the activation LUT midpoint) that the neuron
// top and its activation-address block both rely on.
package neuron_mac_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MAC  = 3'd1,
    ST_BIAS = 3'd2,
    ST_ADDR = 3'd3,
    ST_LUTW = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Ceil-log2 for elaboration-time width sizing; clog2_f(1) = 0.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // LUT address that corresponds to a biased sum of zero.
  function automatic int lut_mid_f(input int aw);
    return 1 << (aw - 1);
  endfunction

endpackage

// File: rtl/neuron_mac_seq_act_addr.sv
// Combinational activation-address block for the neuron.
// Shifts the accumulator down, adds the bias, saturates the biased sum to
// signed DW+1 bits (flagging any clip), and separately turns a registered
// biased sum into a clamped activation LUT address around LUT_MID.
// Ports:
//   acc    in   ACC_W  signed accumulator
//   bias   in   DW     signed bias, added after the shift
//   s_in   in   DW+1   registered saturated sum used for address generation
//   s_sat  out  DW+1   saturated biased sum
//   sat    out  1      biased sum was clipped
//   addr   out  AW     LUT address, clamped to [0, 2**AW-1]
module neuron_mac_seq_act_addr
  import neuron_mac_seq_pkg::*;
#(
  parameter int ACC_W      = 38,
  parameter int DW         = 17,
  parameter int SHIFT      = 21,
  parameter int AW         = 11,
  parameter int ADDR_SHIFT = 7
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [DW-1:0]    bias,
  input  logic signed [DW:0]      s_in,
  output logic signed [DW:0]      s_sat,
  output logic                    sat,
  output logic [AW-1:0]           addr
);

  // One guard bit over the accumulator keeps the bias add exact.
  localparam int SUM_W = ACC_W + 1;
  localparam int AD_W  = (((DW + 1) > AW) ? (DW + 1) : AW) + 1;

  localparam logic signed [SUM_W-1:0] S_MAX = {{(SUM_W-DW){1'b0}}, {DW{1'b1}}};
  localparam logic signed [SUM_W-1:0] S_MIN = {{(SUM_W-DW){1'b1}}, {DW{1'b0}}};
  localparam logic signed [AD_W-1:0]  A_MAX = {{(AD_W-AW){1'b0}}, {AW{1'b1}}};
  localparam logic signed [AD_W-1:0]  A_MID = AD_W'(lut_mid_f(AW));

  function automatic logic clips(input logic signed [SUM_W-1:0] v);
    return (v > S_MAX) || (v < S_MIN);
  endfunction

  function automatic logic signed [DW:0] saturate(input logic signed [SUM_W-1:0] v);
    logic signed [DW:0] r;
    if (v > S_MAX)      r = S_MAX[DW:0];
    else if (v < S_MIN) r = S_MIN[DW:0];
    else                r = v[DW:0];
    return r;
  endfunction

  function automatic logic [AW-1:0] clamp_addr(input logic signed [AD_W-1:0] v);
    logic [AW-1:0] r;
    if (v[AD_W-1])      r = '0;
    else if (v > A_MAX) r = '1;
    else                r = v[AW-1:0];
    return r;
  endfunction

  logic signed [ACC_W-1:0] shifted;
  logic signed [SUM_W-1:0] sum;
  logic signed [DW:0]      off;
  logic signed [AD_W-1:0]  addr_raw;

  always_comb begin
    shifted  = acc >>> SHIFT;
    sum      = {shifted[ACC_W-1], shifted} + {{(SUM_W-DW){bias[DW-1]}}, bias};
    s_sat    = saturate(sum);
    sat      = clips(sum);
    off      = s_in >>> ADDR_SHIFT;
    addr_raw = {{(AD_W-DW-1){off[DW]}}, off} + A_MID;
    addr     = clamp_addr(addr_raw);
  end

endmodule

// File: rtl/neuron_mac_seq.sv
// Time-multiplexed single neuron.
// Accepts one input/weight vector plus bias, runs N_IN signed MACs on a
// single multiplier, shifts/biases/saturates the sum, presents a clamped
// address to the external activation LUT and returns the LUT word as y.
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   in_valid / in_ready   input handshake (ready only while idle)
//   x_flat, w_flat        N_IN packed DW-bit signed inputs / weights
//   bias                  DW-bit signed bias
//   lut_addr / lut_data   registered LUT address, LUT word LUT_LAT cycles later
//   out_valid / out_ready output handshake
//   y, sat                activation result and saturation flag
module neuron_mac_seq
  import neuron_mac_seq_pkg::*;
#(
  parameter int N_IN       = 13,
  parameter int DW         = 17,
  parameter int SHIFT      = 21,
  parameter int AW         = 11,
  parameter int ADDR_SHIFT = 7,
  parameter int LUT_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN*DW-1:0]   x_flat,
  input  logic [N_IN*DW-1:0]   w_flat,
  input  logic signed [DW-1:0] bias,
  output logic [AW-1:0]        lut_addr,
  input  logic [DW-1:0]        lut_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        y,
  output logic                 sat
);

  // Guard bits of clog2(N_IN) make the accumulator overflow-free.
  localparam int ACC_W = 2 * DW + clog2_f(N_IN);
  localparam int IDX_W = (N_IN > 1) ? clog2_f(N_IN) : 1;
  localparam int CNT_W = clog2_f(LUT_LAT + 1);
  localparam logic [AW-1:0]    LUT_MID  = AW'(lut_mid_f(AW));
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LUT_LAT);

  state_t state, state_nxt;

  logic [IDX_W-1:0]        idx;
  logic [CNT_W-1:0]        cnt;
  logic signed [DW-1:0]    x_p0 [N_IN];
  logic signed [DW-1:0]    w_p0 [N_IN];
  logic signed [DW-1:0]    bias_p0;
  logic signed [2*DW-1:0]  prod_p0;
  logic signed [ACC_W-1:0] acc_p1;
  logic signed [DW:0]      s_p2;
  logic                    sat_p2;
  logic signed [DW:0]      s_sat;
  logic                    sat_w;
  logic [AW-1:0]           addr_w;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)        state_nxt = ST_MAC;
      ST_MAC:  if (idx == IDX_LAST) state_nxt = ST_BIAS;
      ST_BIAS:                      state_nxt = ST_ADDR;
      ST_ADDR:                      state_nxt = ST_LUTW;
      ST_LUTW: if (cnt == '0)       state_nxt = ST_DONE;
      ST_DONE: if (out_ready)       state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_IDLE);
  end

  // Stage p0: operand capture at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && in_valid) begin
      for (int i = 0; i < N_IN; i++) begin
        x_p0[i] <= x_flat[i*DW +: DW];
        w_p0[i] <= w_flat[i*DW +: DW];
      end
      bias_p0 <= bias;
    end
  end

  always_comb begin
    prod_p0 = (2*DW)'(x_p0[idx]) * (2*DW)'(w_p0[idx]);
  end

  neuron_mac_seq_act_addr #(
    .ACC_W      (ACC_W),
    .DW         (DW),
    .SHIFT      (SHIFT),
    .AW         (AW),
    .ADDR_SHIFT (ADDR_SHIFT)
  ) u_act_addr (
    .acc   (acc_p1),
    .bias  (bias_p0),
    .s_in  (s_p2),
    .s_sat (s_sat),
    .sat   (sat_w),
    .addr  (addr_w)
  );

  // Stages p1/p2 and output: accumulate, bias/saturate, address, LUT capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      cnt       <= '0;
      acc_p1    <= '0;
      s_p2      <= '0;
      sat_p2    <= 1'b0;
      lut_addr  <= LUT_MID;
      y         <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            acc_p1 <= '0;
            idx    <= '0;
          end
        end
        ST_MAC: begin
          acc_p1 <= acc_p1 + ACC_W'(prod_p0);
          idx    <= idx + 1'b1;
        end
        ST_BIAS: begin
          s_p2   <= s_sat;
          sat_p2 <= sat_w;
        end
        ST_ADDR: begin
          lut_addr <= addr_w;
          cnt      <= CNT_INIT;
        end
        // The wait spans LUT_LAT+1 cycles so the word registered by the
        // LUT after the address update is the one captured.
        ST_LUTW: begin
          if (cnt == '0) begin
            y         <= lut_data;
            sat       <= sat_p2;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_seq.sv
module tb_neuron_mac_seq;

  localparam int DW  = 17;
  localparam int N_A = 13;
  localparam int N_B = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instances A (defaults) and C (SHIFT=10) share all inputs and run in lockstep.
  logic               in_valid_a  = 1'b0;
  logic               out_ready_a = 1'b0;
  logic [N_A*DW-1:0]  x_flat_a    = '0;
  logic [N_A*DW-1:0]  w_flat_a    = '0;
  logic [DW-1:0]      bias_a      = '0;
  logic               in_ready_a, out_valid_a, sat_a;
  logic [10:0]        lut_addr_a;
  logic [DW-1:0]      lut_data_a, y_a;
  logic               in_ready_c, out_valid_c, sat_c;
  logic [10:0]        lut_addr_c;
  logic [DW-1:0]      lut_data_c, y_c;

  logic               in_valid_b  = 1'b0;
  logic               out_ready_b = 1'b0;
  logic [N_B*DW-1:0]  x_flat_b    = '0;
  logic [N_B*DW-1:0]  w_flat_b    = '0;
  logic [DW-1:0]      bias_b      = '0;
  logic               in_ready_b, out_valid_b, sat_b;
  logic [10:0]        lut_addr_b;
  logic [DW-1:0]      lut_data_b, y_b;

  neuron_mac_seq dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .x_flat(x_flat_a), .w_flat(w_flat_a), .bias(bias_a),
    .lut_addr(lut_addr_a), .lut_data(lut_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .y(y_a), .sat(sat_a)
  );

  neuron_mac_seq #(.SHIFT(10)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_c),
    .x_flat(x_flat_a), .w_flat(w_flat_a), .bias(bias_a),
    .lut_addr(lut_addr_c), .lut_data(lut_data_c),
    .out_valid(out_valid_c), .out_ready(out_ready_a), .y(y_c), .sat(sat_c)
  );

  neuron_mac_seq #(.N_IN(N_B), .LUT_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .x_flat(x_flat_b), .w_flat(w_flat_b), .bias(bias_b),
    .lut_addr(lut_addr_b), .lut_data(lut_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .y(y_b), .sat(sat_b)
  );

  // Behavioural LUT ROMs: word = zero-extended address, LUT_LAT register stages.
  logic [10:0] lut_pipe_a = '0;
  logic [10:0] lut_pipe_c = '0;
  logic [10:0] lut_pipe_b [3] = '{default: '0};
  always @(posedge clk) begin
    lut_pipe_a    <= lut_addr_a;
    lut_pipe_c    <= lut_addr_c;
    lut_pipe_b[0] <= lut_addr_b;
    lut_pipe_b[1] <= lut_pipe_b[0];
    lut_pipe_b[2] <= lut_pipe_b[1];
  end
  assign lut_data_a = {6'b0, lut_pipe_a};
  assign lut_data_c = {6'b0, lut_pipe_c};
  assign lut_data_b = {6'b0, lut_pipe_b[2]};

  int checks   = 0;
  int failures = 0;
  int xa [N_A];
  int wa [N_A];
  int bv;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: exact integer dot product, floor shift, bias, clip, address clamp.
  function automatic void model(input int n, input int shift,
                                output logic [63:0] addr, output logic [63:0] satv);
    longint acc, s, lim, a;
    acc = 0;
    for (int i = 0; i < n; i++) acc += longint'(xa[i]) * longint'(wa[i]);
    s    = (acc >>> shift) + longint'(bv);
    lim  = longint'(1) << DW;
    satv = 0;
    if (s > lim - 1) begin s = lim - 1; satv = 1; end
    if (s < -lim)    begin s = -lim;    satv = 1; end
    a = 1024 + (s >>> 7);
    if (a < 0)    a = 0;
    if (a > 2047) a = 2047;
    addr = 64'(a);
  endfunction

  function automatic int rnd_word();
    return int'($urandom_range(0, 131071)) - 65536;
  endfunction

  task automatic set_all(input int xv, input int wv, input int b);
    for (int i = 0; i < N_A; i++) begin xa[i] = xv; wa[i] = wv; end
    bv = b;
  endtask

  task automatic set_rand();
    for (int i = 0; i < N_A; i++) begin xa[i] = rnd_word(); wa[i] = rnd_word(); end
    bv = rnd_word();
  endtask

  task automatic drive_a();
    for (int i = 0; i < N_A; i++) begin
      x_flat_a[i*DW +: DW] = xa[i][DW-1:0];
      w_flat_a[i*DW +: DW] = wa[i][DW-1:0];
    end
    bias_a = bv[DW-1:0];
  endtask

  task automatic scramble_a();
    for (int i = 0; i < N_A; i++) begin
      x_flat_a[i*DW +: DW] = DW'($urandom);
      w_flat_a[i*DW +: DW] = DW'($urandom);
    end
    bias_a = DW'($urandom);
  endtask

  task automatic run_ac(input string tag, input bit hold);
    logic [63:0] ea, sa, ec, sc;
    int lat, n;
    model(N_A, 21, ea, sa);
    model(N_A, 10, ec, sc);
    n = 0;
    while (!in_ready_a && n < 100) begin @(posedge clk); #1; n++; end
    check({tag, ".in_ready"}, in_ready_a, 1);
    drive_a();
    in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    scramble_a();
    lat = 0;
    while (!out_valid_a && lat < 100) begin @(posedge clk); #1; lat++; end
    check({tag, ".latency"}, lat, 17);
    check({tag, ".addr"}, lut_addr_a, ea);
    check({tag, ".y"}, y_a, ea);
    check({tag, ".sat"}, sat_a, sa);
    check({tag, ".c_valid"}, out_valid_c, 1);
    check({tag, ".c_addr"}, lut_addr_c, ec);
    check({tag, ".c_y"}, y_c, ec);
    check({tag, ".c_sat"}, sat_c, sc);
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        scramble_a();
        in_valid_a = 1'b1;
        @(posedge clk); #1;
        check({tag, ".hold_valid"}, out_valid_a, 1);
        check({tag, ".hold_y"}, y_a, ea);
        check({tag, ".hold_sat"}, sat_a, sa);
        check({tag, ".hold_in_ready"}, in_ready_a, 0);
      end
      in_valid_a = 1'b0;
    end
    out_ready_a = 1'b1;
    @(posedge clk); #1;
    out_ready_a = 1'b0;
    check({tag, ".valid_drop"}, out_valid_a, 0);
    check({tag, ".c_valid_drop"}, out_valid_c, 0);
    check({tag, ".idle_ready"}, in_ready_a, 1);
    if (hold) begin
      @(posedge clk); #1;
      check({tag, ".single_result"}, out_valid_a, 0);
      check({tag, ".still_idle"}, in_ready_a, 1);
    end
  endtask

  task automatic run_b(input string tag);
    logic [63:0] eb, sb;
    int lat, n;
    model(N_B, 21, eb, sb);
    n = 0;
    while (!in_ready_b && n < 100) begin @(posedge clk); #1; n++; end
    check({tag, ".in_ready"}, in_ready_b, 1);
    for (int i = 0; i < N_B; i++) begin
      x_flat_b[i*DW +: DW] = xa[i][DW-1:0];
      w_flat_b[i*DW +: DW] = wa[i][DW-1:0];
    end
    bias_b = bv[DW-1:0];
    in_valid_b = 1'b1;
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    x_flat_b = '0;
    bias_b   = DW'($urandom);
    lat = 0;
    while (!out_valid_b && lat < 100) begin @(posedge clk); #1; lat++; end
    check({tag, ".latency"}, lat, 10);
    check({tag, ".addr"}, lut_addr_b, eb);
    check({tag, ".y"}, y_b, eb);
    check({tag, ".sat"}, sat_b, sb);
    out_ready_b = 1'b1;
    @(posedge clk); #1;
    out_ready_b = 1'b0;
    check({tag, ".valid_drop"}, out_valid_b, 0);
    check({tag, ".idle_ready"}, in_ready_b, 1);
  endtask

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst.a_in_ready", in_ready_a, 1);
    check("rst.a_out_valid", out_valid_a, 0);
    check("rst.a_y", y_a, 0);
    check("rst.a_sat", sat_a, 0);
    check("rst.a_addr", lut_addr_a, 1024);
    check("rst.b_in_ready", in_ready_b, 1);
    check("rst.b_addr", lut_addr_b, 1024);
    check("rst.c_out_valid", out_valid_c, 0);

    set_all(0, 0, 0);
    run_ac("zero", 0);
    set_all(0, 0, 0); xa[0] = 16384; wa[0] = 16384;
    run_ac("one_term", 0);
    set_all(0, 0, -1280);
    run_ac("neg_bias", 0);
    set_all(0, 0, -65536);
    run_ac("min_bias", 0);
    set_all(65535, 65535, 65535);
    run_ac("pos_max", 0);
    set_all(-65536, 65535, -65536);
    run_ac("neg_max", 0);
    set_all(-65536, -65536, 65535);
    run_ac("sq_min", 0);

    set_rand();
    run_ac("backpressure", 1);

    for (int r = 0; r < 6; r++) begin
      set_rand();
      run_ac($sformatf("rand%0d", r), 0);
    end

    // Reset during MAC at idx 6 discards the vector.
    set_rand();
    drive_a();
    in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.out_valid", out_valid_a, 0);
    check("abort.y", y_a, 0);
    check("abort.sat", sat_a, 0);
    check("abort.addr", lut_addr_a, 1024);
    check("abort.in_ready", in_ready_a, 1);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (out_valid_a || out_valid_c) seen++;
    end
    check("abort.no_result", seen, 0);
    set_rand();
    run_ac("after_abort", 0);

    set_all(0, 0, 0);
    run_b("b_zero");
    set_all(0, 0, 0); xa[0] = 16384; wa[0] = 16384;
    run_b("b_one_term");
    for (int r = 0; r < 3; r++) begin
      set_rand();
      run_b($sformatf("b_rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
